// File: rtl/fp_pkg.sv
// Shared floating-point definitions for the fp_* units: rounding-mode codes,
// operand classification record and a format-generic canonical quiet NaN.
package fp_pkg;

    localparam logic [2:0] RNE = 3'd0;
    localparam logic [2:0] RTZ = 3'd1;
    localparam logic [2:0] RDN = 3'd2;
    localparam logic [2:0] RUP = 3'd3;
    localparam logic [2:0] RMM = 3'd4;

    localparam int FP_MAX_W = 128;

    typedef struct packed {
        logic iszero;
        logic isinf;
        logic isqnan;
        logic issnan;
        logic isdenorm;
    } fp_class_t;

    // {sign=0, exponent all ones, mantissa MSB set, rest clear}, right-aligned in FP_MAX_W bits
    function automatic logic [FP_MAX_W-1:0] canonical_nan(input int exp_w, input int man_w);
        logic [FP_MAX_W-1:0] one;
        one = FP_MAX_W'(1);
        return (((one << exp_w) - one) << man_w) | (one << (man_w - 1));
    endfunction

endpackage

// File: rtl/fp_classify.sv
// Combinational operand classifier: splits an exponent/mantissa pair into
// zero, infinity, quiet NaN, signalling NaN and denormal.
module fp_classify
    import fp_pkg::*;
#(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23
) (
    input  logic [EXP_W-1:0] exp_field,
    input  logic [MAN_W-1:0] man_field,
    output fp_class_t        cls
);

    logic exp_zero;
    logic exp_ones;
    logic man_zero;

    assign exp_zero = (exp_field == '0);
    assign exp_ones = (exp_field == '1);
    assign man_zero = (man_field == '0);

    assign cls.iszero   = exp_zero & man_zero;
    assign cls.isdenorm = exp_zero & ~man_zero;
    assign cls.isinf    = exp_ones & man_zero;
    assign cls.isqnan   = exp_ones & man_field[MAN_W-1];
    assign cls.issnan   = exp_ones & ~man_field[MAN_W-1] & ~man_zero;

endmodule

// File: rtl/fp_mul_param_pipe.sv
// Parametrised IEEE-754 multiplier, 4-stage pipeline, one result per cycle.
// Define FP_MUL_BACKPRESSURE_EN to add the out_ready port and pipeline stalling.
module fp_mul_param_pipe
    import fp_pkg::*;
#(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   valid_data_in,
    input  logic [EXP_W+MAN_W:0]   in1,
    input  logic [EXP_W+MAN_W:0]   in2,
    input  logic [2:0]             rounding_mode,
    output logic                   in_ready,
`ifdef FP_MUL_BACKPRESSURE_EN
    input  logic                   out_ready,
`endif
    output logic [EXP_W+MAN_W:0]   out,
    output logic                   overflow,
    output logic                   underflow,
    output logic                   inexact,
    output logic                   invalid_operation,
    output logic                   valid_data_out
);

    localparam int W    = 1 + EXP_W + MAN_W;
    localparam int BIAS = 2**(EXP_W-1) - 1;
    localparam int XW   = EXP_W + 2;
    localparam int PW   = 2 * (MAN_W + 1);

    localparam logic signed [XW-1:0] BIAS_X = XW'(BIAS);
    localparam logic signed [XW-1:0] EMAX_X = XW'(2**EXP_W - 1);
    localparam logic signed [XW-1:0] ONE_X  = XW'(1);
    localparam logic signed [XW-1:0] ZERO_X = XW'(0);
    localparam logic [W-1:0] CANON_NAN = W'(canonical_nan(EXP_W, MAN_W));
    localparam logic [W-1:0] QUIET_BIT = W'(1) << (MAN_W - 1);

    logic stall;
`ifdef FP_MUL_BACKPRESSURE_EN
    assign stall = valid_data_out & ~out_ready;
`else
    assign stall = 1'b0;
`endif
    assign in_ready = ~stall;

    // ---- S1: classify and resolve special operands ----
    fp_class_t cls1, cls2;

    fp_classify #(.EXP_W(EXP_W), .MAN_W(MAN_W)) u_cls1 (
        .exp_field (in1[W-2 -: EXP_W]),
        .man_field (in1[MAN_W-1:0]),
        .cls       (cls1)
    );

    fp_classify #(.EXP_W(EXP_W), .MAN_W(MAN_W)) u_cls2 (
        .exp_field (in2[W-2 -: EXP_W]),
        .man_field (in2[MAN_W-1:0]),
        .cls       (cls2)
    );

    logic         sign_c;
    logic         zero1_c, zero2_c;
    logic         spec_c, spec_inv_c;
    logic [W-1:0] spec_res_c;
    logic [2:0]   rm_c;

    assign sign_c  = in1[W-1] ^ in2[W-1];
    assign zero1_c = cls1.iszero | cls1.isdenorm;
    assign zero2_c = cls2.iszero | cls2.isdenorm;
    assign rm_c    = (rounding_mode > RMM) ? RNE : rounding_mode;

    always_comb begin
        spec_c     = 1'b1;
        spec_inv_c = 1'b0;
        spec_res_c = '0;
        if (cls1.isqnan) begin
            spec_res_c = in1;
        end else if (cls2.isqnan) begin
            spec_res_c = in2;
        end else if (cls1.issnan) begin
            spec_res_c = in1 | QUIET_BIT;
            spec_inv_c = 1'b1;
        end else if (cls2.issnan) begin
            spec_res_c = in2 | QUIET_BIT;
            spec_inv_c = 1'b1;
        end else if ((cls1.isinf && zero2_c) || (cls2.isinf && zero1_c)) begin
            spec_res_c = CANON_NAN;
            spec_inv_c = 1'b1;
        end else if (cls1.isinf || cls2.isinf) begin
            spec_res_c = {sign_c, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
        end else if (zero1_c || zero2_c) begin
            spec_res_c = {sign_c, {(W-1){1'b0}}};
        end else begin
            spec_c = 1'b0;
        end
    end

    logic             vld_p1, sign_p1, spec_p1, spec_inv_p1;
    logic [EXP_W-1:0] exp1_p1, exp2_p1;
    logic [MAN_W:0]   man1_p1, man2_p1;
    logic [2:0]       rm_p1;
    logic [W-1:0]     spec_res_p1;

    always_ff @(posedge clk) begin
        if (rst) begin
            vld_p1      <= 1'b0;
            sign_p1     <= 1'b0;
            exp1_p1     <= '0;
            exp2_p1     <= '0;
            man1_p1     <= '0;
            man2_p1     <= '0;
            rm_p1       <= '0;
            spec_p1     <= 1'b0;
            spec_inv_p1 <= 1'b0;
            spec_res_p1 <= '0;
        end else if (!stall) begin
            vld_p1      <= valid_data_in;
            sign_p1     <= sign_c;
            exp1_p1     <= in1[W-2 -: EXP_W];
            exp2_p1     <= in2[W-2 -: EXP_W];
            man1_p1     <= {1'b1, in1[MAN_W-1:0]};
            man2_p1     <= {1'b1, in2[MAN_W-1:0]};
            rm_p1       <= rm_c;
            spec_p1     <= spec_c;
            spec_inv_p1 <= spec_inv_c;
            spec_res_p1 <= spec_res_c;
        end
    end

    // ---- S2: exponent sum and significand product ----
    logic signed [XW-1:0] exp_sum_c;
    assign exp_sum_c = $signed({2'b00, exp1_p1}) + $signed({2'b00, exp2_p1}) - BIAS_X;

    logic                 vld_p2, sign_p2, spec_p2, spec_inv_p2;
    logic signed [XW-1:0] exp_p2;
    logic [PW-1:0]        prod_p2;
    logic [2:0]           rm_p2;
    logic [W-1:0]         spec_res_p2;

    always_ff @(posedge clk) begin
        if (rst) begin
            vld_p2      <= 1'b0;
            sign_p2     <= 1'b0;
            exp_p2      <= '0;
            prod_p2     <= '0;
            rm_p2       <= '0;
            spec_p2     <= 1'b0;
            spec_inv_p2 <= 1'b0;
            spec_res_p2 <= '0;
        end else if (!stall) begin
            vld_p2      <= vld_p1;
            sign_p2     <= sign_p1;
            exp_p2      <= exp_sum_c;
            prod_p2     <= PW'(man1_p1) * PW'(man2_p1);
            rm_p2       <= rm_p1;
            spec_p2     <= spec_p1;
            spec_inv_p2 <= spec_inv_p1;
            spec_res_p2 <= spec_res_p1;
        end
    end

    // ---- S3: normalise into kept bits, guard and sticky ----
    logic signed [XW-1:0] exp_n_c;
    logic [MAN_W:0]       kept_c;
    logic                 guard_c, sticky_c;

    always_comb begin
        if (prod_p2[PW-1]) begin
            exp_n_c  = exp_p2 + ONE_X;
            kept_c   = prod_p2[PW-1 -: MAN_W+1];
            guard_c  = prod_p2[MAN_W];
            sticky_c = |prod_p2[MAN_W-1:0];
        end else begin
            exp_n_c  = exp_p2;
            kept_c   = prod_p2[PW-2 -: MAN_W+1];
            guard_c  = prod_p2[MAN_W-1];
            sticky_c = |prod_p2[MAN_W-2:0];
        end
    end

    logic                 vld_p3, sign_p3, spec_p3, spec_inv_p3;
    logic                 guard_p3, sticky_p3;
    logic signed [XW-1:0] exp_p3;
    logic [MAN_W:0]       kept_p3;
    logic [2:0]           rm_p3;
    logic [W-1:0]         spec_res_p3;

    always_ff @(posedge clk) begin
        if (rst) begin
            vld_p3      <= 1'b0;
            sign_p3     <= 1'b0;
            exp_p3      <= '0;
            kept_p3     <= '0;
            guard_p3    <= 1'b0;
            sticky_p3   <= 1'b0;
            rm_p3       <= '0;
            spec_p3     <= 1'b0;
            spec_inv_p3 <= 1'b0;
            spec_res_p3 <= '0;
        end else if (!stall) begin
            vld_p3      <= vld_p2;
            sign_p3     <= sign_p2;
            exp_p3      <= exp_n_c;
            kept_p3     <= kept_c;
            guard_p3    <= guard_c;
            sticky_p3   <= sticky_c;
            rm_p3       <= rm_p2;
            spec_p3     <= spec_p2;
            spec_inv_p3 <= spec_inv_p2;
            spec_res_p3 <= spec_res_p2;
        end
    end

    // ---- S4: round, range-check, pack result and flags ----
    logic                 inc_c;
    logic [MAN_W+1:0]     rnd_c;
    logic signed [XW-1:0] exp_r_c;
    logic [MAN_W-1:0]     frac_c;
    logic [W-1:0]         res_c, inf_c, max_c;
    logic                 ov_c, uf_c, ix_c, inv_c;

    always_comb begin
        inc_c   = 1'b0;
        rnd_c   = '0;
        exp_r_c = exp_p3;
        frac_c  = '0;
        res_c   = '0;
        ov_c    = 1'b0;
        uf_c    = 1'b0;
        ix_c    = 1'b0;
        inv_c   = 1'b0;
        inf_c   = {sign_p3, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
        max_c   = {sign_p3, {(EXP_W-1){1'b1}}, 1'b0, {MAN_W{1'b1}}};

        case (rm_p3)
            RTZ:     inc_c = 1'b0;
            RDN:     inc_c = sign_p3 & (guard_p3 | sticky_p3);
            RUP:     inc_c = ~sign_p3 & (guard_p3 | sticky_p3);
            RMM:     inc_c = guard_p3;
            default: inc_c = guard_p3 & (sticky_p3 | kept_p3[0]);
        endcase

        rnd_c = {1'b0, kept_p3} + {{(MAN_W+1){1'b0}}, inc_c};
        if (rnd_c[MAN_W+1]) begin
            exp_r_c = exp_p3 + ONE_X;
            frac_c  = rnd_c[MAN_W:1];
        end else begin
            frac_c  = rnd_c[MAN_W-1:0];
        end

        if (spec_p3) begin
            res_c = spec_res_p3;
            inv_c = spec_inv_p3;
        end else if (exp_r_c >= EMAX_X) begin
            ov_c = 1'b1;
            ix_c = 1'b1;
            case (rm_p3)
                RTZ:     res_c = max_c;
                RUP:     res_c = sign_p3 ? max_c : inf_c;
                RDN:     res_c = sign_p3 ? inf_c : max_c;
                default: res_c = inf_c;
            endcase
        end else if (exp_r_c <= ZERO_X) begin
            res_c = {sign_p3, {(W-1){1'b0}}};
            uf_c  = 1'b1;
            ix_c  = 1'b1;
        end else begin
            res_c = {sign_p3, exp_r_c[EXP_W-1:0], frac_c};
            ix_c  = guard_p3 | sticky_p3;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_data_out    <= 1'b0;
            out               <= '0;
            overflow          <= 1'b0;
            underflow         <= 1'b0;
            inexact           <= 1'b0;
            invalid_operation <= 1'b0;
        end else if (!stall) begin
            valid_data_out    <= vld_p3;
            out               <= res_c;
            overflow          <= ov_c;
            underflow         <= uf_c;
            inexact           <= ix_c;
            invalid_operation <= inv_c;
        end
    end

endmodule

// File: tb/tb_fp_mul_param_pipe.sv
// Directed bench for fp_mul_param_pipe: binary32 vector table, binary16 stream
// with mid-stream reset, and a stall sequence when backpressure is compiled in.
module tb_fp_mul_param_pipe;
    import fp_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        vin, in_rdy, ov, uf, ix, inv, vout;
    logic [31:0] a, b, y;
    logic [2:0]  rm;
    logic        h_vin, h_rdy, hov, huf, hix, hinv, hvout;
    logic [15:0] ha, hb, hy;
    logic [2:0]  h_rm;
`ifdef FP_MUL_BACKPRESSURE_EN
    logic        out_rdy, h_out_rdy;
    logic [31:0] q32[$];
    int          rcv;
`endif

    fp_mul_param_pipe #(.EXP_W(8), .MAN_W(23)) dut32 (
        .clk(clk), .rst(rst), .valid_data_in(vin), .in1(a), .in2(b),
        .rounding_mode(rm), .in_ready(in_rdy),
`ifdef FP_MUL_BACKPRESSURE_EN
        .out_ready(out_rdy),
`endif
        .out(y), .overflow(ov), .underflow(uf), .inexact(ix),
        .invalid_operation(inv), .valid_data_out(vout)
    );

    fp_mul_param_pipe #(.EXP_W(5), .MAN_W(10)) dut16 (
        .clk(clk), .rst(rst), .valid_data_in(h_vin), .in1(ha), .in2(hb),
        .rounding_mode(h_rm), .in_ready(h_rdy),
`ifdef FP_MUL_BACKPRESSURE_EN
        .out_ready(h_out_rdy),
`endif
        .out(hy), .overflow(hov), .underflow(huf), .inexact(hix),
        .invalid_operation(hinv), .valid_data_out(hvout)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    typedef struct {
        string       name;
        logic [31:0] a;
        logic [31:0] b;
        logic [2:0]  rm;
        logic [31:0] y;
        logic [3:0]  fl;   // {overflow, underflow, inexact, invalid}
    } vec_t;

    vec_t vecs[$];

    task automatic apply32(input logic [31:0] ia, input logic [31:0] ib, input logic [2:0] irm,
                           output logic [31:0] oy, output logic [3:0] ofl, output int lat);
        @(posedge clk); #1;
        a = ia; b = ib; rm = irm; vin = 1'b1;
        @(posedge clk); #1;
        vin = 1'b0;
        lat = 99; oy = '0; ofl = '0;
        for (int n = 1; n <= 10; n++) begin
            @(negedge clk);
            if (vout) begin
                lat = n; oy = y; ofl = {ov, uf, ix, inv};
                break;
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] ry;
        logic [3:0]  rfl;
        int          lat, got, post;
        logic [15:0] hq[$];

        rst = 1'b1; vin = 1'b0; a = '0; b = '0; rm = RNE;
        h_vin = 1'b0; ha = '0; hb = '0; h_rm = RNE;
`ifdef FP_MUL_BACKPRESSURE_EN
        out_rdy = 1'b1; h_out_rdy = 1'b1;
`endif
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_out32", y, 32'h0);
        check("rst_out16", hy, 16'h0);
        check("rst_valid", {vout, hvout}, 2'b00);
        check("rst_flags", {ov, uf, ix, inv, hov, huf, hix, hinv}, 8'h00);
        rst = 1'b0;
        check("in_ready_idle", in_rdy, 1'b1);

        vecs.push_back('{"mul3",        32'h3FC00000, 32'h40000000, RNE,  32'h40400000, 4'b0000});
        vecs.push_back('{"inf_x_zero",  32'h7F800000, 32'h00000000, RNE,  32'h7FC00000, 4'b0001});
        vecs.push_back('{"snan_in1",    32'h7F800001, 32'h3F800000, RNE,  32'h7FC00001, 4'b0001});
        vecs.push_back('{"snan_in2",    32'h3F800000, 32'hFF800005, RNE,  32'hFFC00005, 4'b0001});
        vecs.push_back('{"qnan_in2",    32'h3F800000, 32'hFFC12345, RNE,  32'hFFC12345, 4'b0000});
        vecs.push_back('{"zero_x_inf",  32'h80000000, 32'hFF800000, RNE,  32'h7FC00000, 4'b0001});
        vecs.push_back('{"inf_neg",     32'h7F800000, 32'hC0000000, RNE,  32'hFF800000, 4'b0000});
        vecs.push_back('{"neg_zero",    32'h00000000, 32'hBF800000, RUP,  32'h80000000, 4'b0000});
        vecs.push_back('{"ovf_rne",     32'h7F7FFFFF, 32'h40000000, RNE,  32'h7F800000, 4'b1010});
        vecs.push_back('{"ovf_rtz",     32'h7F7FFFFF, 32'h40000000, RTZ,  32'h7F7FFFFF, 4'b1010});
        vecs.push_back('{"ovf_rup_neg", 32'hFF7FFFFF, 32'h40000000, RUP,  32'hFF7FFFFF, 4'b1010});
        vecs.push_back('{"ovf_rdn_neg", 32'hFF7FFFFF, 32'h40000000, RDN,  32'hFF800000, 4'b1010});
        vecs.push_back('{"ovf_rup_pos", 32'h7F7FFFFF, 32'h40000000, RUP,  32'h7F800000, 4'b1010});
        vecs.push_back('{"ovf_rdn_pos", 32'h7F7FFFFF, 32'h40000000, RDN,  32'h7F7FFFFF, 4'b1010});
        vecs.push_back('{"tie_rne",     32'h3F800800, 32'h3F800800, RNE,  32'h3F801000, 4'b0010});
        vecs.push_back('{"tie_rup",     32'h3F800800, 32'h3F800800, RUP,  32'h3F801001, 4'b0010});
        vecs.push_back('{"tie_rtz",     32'h3F800800, 32'h3F800800, RTZ,  32'h3F801000, 4'b0010});
        vecs.push_back('{"tie_rmm",     32'h3F800800, 32'h3F800800, RMM,  32'h3F801001, 4'b0010});
        vecs.push_back('{"tie_mode7",   32'h3F800800, 32'h3F800800, 3'd7, 32'h3F801000, 4'b0010});
        vecs.push_back('{"unf_min",     32'h00800000, 32'h3F000000, RNE,  32'h00000000, 4'b0110});
        vecs.push_back('{"unf_deep",    32'h80800000, 32'h00800000, RNE,  32'h80000000, 4'b0110});
        vecs.push_back('{"denorm_in",   32'h80000001, 32'h3F800000, RNE,  32'h80000000, 4'b0000});
        vecs.push_back('{"sq_2p25",     32'hBFC00000, 32'hBFC00000, RNE,  32'h40100000, 4'b0000});
        vecs.push_back('{"ix_rne",      32'h3F800001, 32'h3F800001, RNE,  32'h3F800002, 4'b0010});
        vecs.push_back('{"ix_rdn_neg",  32'hBF800001, 32'h3F800001, RDN,  32'hBF800003, 4'b0010});
        vecs.push_back('{"ix_rup_neg",  32'hBF800001, 32'h3F800001, RUP,  32'hBF800002, 4'b0010});
        vecs.push_back('{"carry_rne",   32'h3FFFF800, 32'h3F800400, RNE,  32'h40000000, 4'b0010});
        vecs.push_back('{"carry_rtz",   32'h3FFFF800, 32'h3F800400, RTZ,  32'h3FFFFFFF, 4'b0010});
        vecs.push_back('{"carry_ovf",   32'h7F7FF800, 32'h3F800400, RNE,  32'h7F800000, 4'b1010});
        vecs.push_back('{"carry_noovf", 32'h7F7FF800, 32'h3F800400, RTZ,  32'h7F7FFFFF, 4'b0010});

        foreach (vecs[i]) begin
            apply32(vecs[i].a, vecs[i].b, vecs[i].rm, ry, rfl, lat);
            check({vecs[i].name, "_out"}, ry, vecs[i].y);
            check({vecs[i].name, "_flags"}, rfl, vecs[i].fl);
            check({vecs[i].name, "_latency"}, lat, 4);
        end

        // binary16: 16 back-to-back ops, 1.0 * x must return x in order
        got = 0;
        for (int c = 0; c < 24; c++) begin
            @(posedge clk); #1;
            h_vin = (c < 16);
            ha    = 16'h3C00;
            hb    = 16'hC000 + 16'(c) * 16'h0101;
            if (c < 16) hq.push_back(hb);
            @(negedge clk);
            if (hvout) begin
                got++;
                if (hq.size() > 0) begin
                    check("h_stream_out", hy, hq.pop_front());
                    check("h_stream_flags", {hov, huf, hix, hinv}, 4'b0000);
                end else begin
                    check("h_stream_extra", 1'b1, 1'b0);
                end
            end
        end
        check("h_stream_count", got, 16);

        // reset while six ops are in flight: only the three already at the output survive
        hq.delete();
        got = 0; post = 0;
        for (int c = 0; c < 16; c++) begin
            @(posedge clk); #1;
            h_vin = (c < 6);
            hb    = 16'h4400 + 16'(c);
            rst   = (c == 6);
            if (c < 6) hq.push_back(hb);
            @(negedge clk);
            if (hvout) begin
                if (c <= 6) begin
                    got++;
                    if (hq.size() > 0) check("h_pre_rst_out", hy, hq.pop_front());
                end else begin
                    post++;
                end
            end
        end
        check("h_pre_rst_count", got, 3);
        check("h_post_rst_valid", post, 0);
        check("post_rst_out32_valid", vout, 1'b0);

`ifdef FP_MUL_BACKPRESSURE_EN
        out_rdy = 1'b0; rcv = 0; q32.delete();
        for (int c = 0; c < 24; c++) begin
            @(posedge clk); #1;
            vin = (c < 4);
            a   = 32'h3F800000;
            b   = 32'h40000000 + (32'(c) << 16);
            rm  = RNE;
            if (c < 4) q32.push_back(b);
            if (c == 7) out_rdy = 1'b1;
            @(negedge clk);
            if (c >= 4 && c <= 6) begin
                check("bp_stall_out", y, 32'h40000000);
                check("bp_stall_valid", vout, 1'b1);
                check("bp_in_ready", in_rdy, 1'b0);
            end
            if (vout && out_rdy) begin
                rcv++;
                if (q32.size() > 0) check("bp_order", y, q32.pop_front());
            end
        end
        check("bp_count", rcv, 4);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
